// File: rtl/hs_pkg.sv
// Shared hard-swish parameter package.
//
// Purpose: one place for the lane geometry and FSM state encoding used by the
// hard-swish datapath blocks (hs_segment and hs_out_serializer), so producer
// and consumer always agree on vector shape.
//
// Contents:
//   HS_OUT_SIZE  - width of one hard-swish result lane
//   HS_LANES     - lanes per packed vector
//   ST_IDLE/SEND - serializer FSM state encoding
//   idx_width()  - lane index counter width for a given lane count
package hs_pkg;

    localparam int HS_OUT_SIZE = 18;
    localparam int HS_LANES    = 16;

    // Serializer FSM encoding. Kept as plain constants so legacy tools and
    // waveform viewers can decode the state register without enum support.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // clog2 of the lane count, but never zero so a one-lane build still
    // has a legal counter declaration.
    function automatic int idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/hs_out_serializer.sv
// Hard-swish output serializer.
//
// Purpose: takes one packed vector of LANES hard-swish results and writes the
// lanes one per cycle into an output buffer at consecutive addresses starting
// at base_addr (address wraps modulo 2^ADDR_WIDTH).
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-low reset
//   in_data    - packed lanes, lane k at [(k+1)*OUT_SIZE-1 : k*OUT_SIZE]
//   in_valid   - in_data/base_addr valid this cycle
//   base_addr  - buffer address of lane 0
//   in_ready   - a vector offered this cycle is accepted
//   wr_en      - wr_addr/wr_data valid toward the buffer
//   wr_addr    - current lane address (base + index)
//   wr_data    - current lane value
//   wr_ready   - buffer accepts the write this cycle
//   done       - one-cycle pulse after the final lane is accepted
//   overflow   - sticky: a vector was offered while in_ready was low
//
// Handshake: both sides use valid/ready. A transfer happens on a rising edge
// where valid and ready are both high; valid never depends on ready, and an
// offered write holds address and data stable until it is accepted. The input
// side does not back-pressure the producer: a vector offered while in_ready is
// low is dropped and recorded in overflow.
module hs_out_serializer
    import hs_pkg::*;
#(
    parameter int OUT_SIZE   = HS_OUT_SIZE,
    parameter int LANES      = HS_LANES,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*OUT_SIZE-1:0] in_data,
    input  logic                      in_valid,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    output logic                      in_ready,
    output logic                      wr_en,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [OUT_SIZE-1:0]       wr_data,
    input  logic                      wr_ready,
    output logic                      done,
    output logic                      overflow
);

    localparam int IDX_W = idx_width(LANES);
    localparam int VEC_W = LANES * OUT_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic [0:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [VEC_W-1:0]      shreg;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  done_q;
    logic                  overflow_q;

    logic wr_accept;
    logic last_lane;
    logic in_accept;

    assign last_lane = (idx == LAST_IDX);
    assign wr_accept = (state == ST_SEND) && wr_ready;

    // Ready in IDLE, or when the final lane is leaving this very cycle so a
    // new vector can follow with no bubble.
    assign in_ready  = (state == ST_IDLE) || (wr_accept && last_lane);
    assign in_accept = in_valid && in_ready;

    // Outputs are decoded straight from registers. On the final lane the shift
    // register and index are deliberately not advanced, so address and data
    // keep their last values once the FSM falls back to IDLE.
    assign wr_en    = (state == ST_SEND);
    assign wr_data  = shreg[OUT_SIZE-1:0];
    assign wr_addr  = base_q + ADDR_WIDTH'(idx);
    assign done     = done_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            shreg      <= '0;
            base_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= wr_accept && last_lane;

            if (in_valid && !in_ready) begin
                overflow_q <= 1'b1;
            end

            if (in_accept) begin
                // Covers both the IDLE start and the back-to-back reload on
                // the last-lane acceptance cycle.
                state  <= ST_SEND;
                shreg  <= in_data;
                base_q <= base_addr;
                idx    <= '0;
            end else if (wr_accept) begin
                if (last_lane) begin
                    state <= ST_IDLE;
                end else begin
                    shreg <= shreg >> OUT_SIZE;
                    idx   <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hs_out_serializer.sv
// Testbench for hs_out_serializer.
//
// Purpose: directed scenarios (single vector, write stall, address wrap,
// back-to-back vectors, overflow, mid-vector reset) with a scoreboard that
// holds every expected buffer write in order.
module tb_hs_out_serializer;

    localparam int OUT_SIZE = 18;
    localparam int LANES    = 16;
    localparam int AW       = 10;
    localparam int VW       = LANES * OUT_SIZE;
    localparam int EW       = 1 + AW + OUT_SIZE;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [VW-1:0]     in_data;
    logic              in_valid;
    logic [AW-1:0]     base_addr;
    logic              in_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [OUT_SIZE-1:0] wr_data;
    logic              wr_ready;
    logic              done;
    logic              overflow;

    hs_out_serializer #(
        .OUT_SIZE  (OUT_SIZE),
        .LANES     (LANES),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .base_addr(base_addr),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .done     (done),
        .overflow (overflow)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {last_lane, addr, data}
    logic [EW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    bit done_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every accepted write must match the queue head; done must
    // appear exactly on the cycle after a last-lane acceptance.
    always @(negedge clk) begin
        if (!rst) begin
            done_pend = 1'b0;
        end else begin
            chk("done", {31'd0, done}, {31'd0, done_pend});
            done_pend = 1'b0;
            if (wr_en && wr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {22'd0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {22'd0, wr_addr}, {22'd0, e[OUT_SIZE +: AW]});
                    chk("wr_data", {14'd0, wr_data}, {14'd0, e[OUT_SIZE-1:0]});
                    done_pend = e[EW-1];
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [VW-1:0] ramp_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) v[k*OUT_SIZE +: OUT_SIZE] = OUT_SIZE'(k * 3);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < LANES; k++)
            v[k*OUT_SIZE +: OUT_SIZE] = OUT_SIZE'($urandom_range(0, (1 << OUT_SIZE) - 1));
        return v;
    endfunction

    // Call just after a rising edge; returns just after the offering edge.
    task automatic send_vec(input logic [AW-1:0] base, input logic [VW-1:0] data, input bit exp_acc);
        in_data   = data;
        base_addr = base;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_acc});
        if (exp_acc) begin
            for (int k = 0; k < LANES; k++)
                exp_q.push_back({(k == LANES - 1), AW'(base + AW'(k)), data[k*OUT_SIZE +: OUT_SIZE]});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_vec();
        base_addr = 10'h155;
        wr_ready  = 1'b1;

        // Reset, with in_valid asserted throughout (must be ignored).
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",    {31'd0, wr_en},    0);
        chk("rst_done",     {31'd0, done},     0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_wr_addr",  {22'd0, wr_addr},  0);
        chk("rst_wr_data",  {14'd0, wr_data},  0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, wr_en}, 0);
        @(posedge clk);
        #1;

        // Single vector, ramp data, 1-cycle latency, done by N+LANES.
        send_vec(10'h100, ramp_vec(), 1'b1);
        chk("first_lane_en", {31'd0, wr_en}, 1);
        repeat (LANES) @(posedge clk);
        @(negedge clk);
        chk("single_all_written", exp_q.size(), 0);
        chk("single_done", {31'd0, done}, 1);
        chk("idle_wr_en", {31'd0, wr_en}, 0);
        chk("idle_hold_addr", {22'd0, wr_addr}, 32'h10F);
        chk("idle_hold_data", {14'd0, wr_data}, 45);
        @(posedge clk);
        #1;

        // Stall lane 5 for three cycles.
        send_vec(10'h100, ramp_vec(), 1'b1);
        repeat (5) @(posedge clk);
        #1;
        wr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_wr_en", {31'd0, wr_en}, 1);
            chk("stall_addr", {22'd0, wr_addr}, 32'h105);
            chk("stall_data", {14'd0, wr_data}, 15);
            @(posedge clk);
            #1;
        end
        wr_ready = 1'b1;
        drain(40);

        // Address wrap: 0x3FA + 6 wraps to 0x000.
        send_vec(10'h3FA, ramp_vec(), 1'b1);
        drain(40);

        // Back-to-back: second vector offered on last-lane acceptance.
        send_vec(10'h040, rand_vec(), 1'b1);
        repeat (LANES - 1) @(posedge clk);
        #1;
        send_vec(10'h080, rand_vec(), 1'b1);
        for (int c = 0; c < LANES; c++) begin
            @(negedge clk);
            chk("b2b_no_bubble", {31'd0, wr_en}, 1);
            @(posedge clk);
        end
        #1;
        drain(40);
        chk("b2b_no_overflow", {31'd0, overflow}, 0);

        // Overflow: offer at lane 3 of an in-flight vector.
        send_vec(10'h200, ramp_vec(), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        send_vec(10'h300, rand_vec(), 1'b0);
        chk("overflow_set", {31'd0, overflow}, 1);
        drain(40);
        chk("overflow_sticky", {31'd0, overflow}, 1);

        // Reset at lane 8: in-flight vector abandoned.
        send_vec(10'h120, rand_vec(), 1'b1);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_wr_en",    {31'd0, wr_en},    0);
        chk("mid_rst_addr",     {22'd0, wr_addr},  0);
        chk("mid_rst_data",     {14'd0, wr_data},  0);
        chk("mid_rst_done",     {31'd0, done},     0);
        chk("mid_rst_overflow", {31'd0, overflow}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_quiet", {31'd0, wr_en}, 0);
        @(posedge clk);
        #1;

        // Fresh random vector after reset, with random stalls.
        send_vec(AW'($urandom_range(0, (1 << AW) - 1)), rand_vec(), 1'b1);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            wr_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        wr_ready = 1'b1;
        drain(40);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
